// File: rtl/instr_decode_ctrl_pkg.sv
// Shared constants for the decode-stage controller: instruction field layout,
// opcodes, FSM encoding and the registered ID/EX record.
package instr_decode_ctrl_pkg;

  localparam int INS_W  = 20;
  localparam int ADDR_W = 8;
  localparam int OPC_W  = 5;
  localparam int REG_W  = 3;
  localparam int IMM_W  = 8;

  localparam int OPC_LSB = 15;
  localparam int RD_LSB  = 12;
  localparam int RS_LSB  = 9;
  localparam int RT_LSB  = 6;
  localparam int IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OP_NOP = 5'h00;
  localparam logic [OPC_W-1:0] OP_LD  = 5'h10;
  localparam logic [OPC_W-1:0] OP_ST  = 5'h11;
  localparam logic [OPC_W-1:0] OP_JMP = 5'h18;
  localparam logic [OPC_W-1:0] OP_HLT = 5'h1F;

  localparam logic [INS_W-1:0] NOP_WORD = '0;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  // An all-zero record is a bubble: opcode NOP, zero fields, valid=0.
  typedef struct packed {
    logic              valid;
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] pc;
  } idex_t;

endpackage

// File: rtl/instr_decode_ctrl_if.sv
// Fetch-side and execute-side signals of the decode controller.
// master = fetch/execute environment, slave = the decode controller.
interface instr_decode_ctrl_if;
  import instr_decode_ctrl_pkg::*;

  logic [INS_W-1:0]  ins;
  logic [ADDR_W-1:0] current_address;
  logic [ADDR_W-1:0] jmp_loc;
  logic              pc_mux_sel;
  logic              stall;
  logic              stall_pm;
  logic              id_valid;
  logic [OPC_W-1:0]  id_opcode;
  logic [REG_W-1:0]  id_rd;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [IMM_W-1:0]  id_imm;
  logic [ADDR_W-1:0] id_pc;
  logic              halted;

  modport master (
    output ins, current_address,
    input  jmp_loc, pc_mux_sel, stall, stall_pm, id_valid, id_opcode,
           id_rd, id_rs, id_rt, id_imm, id_pc, halted
  );

  modport slave (
    input  ins, current_address,
    output jmp_loc, pc_mux_sel, stall, stall_pm, id_valid, id_opcode,
           id_rd, id_rs, id_rt, id_imm, id_pc, halted
  );

endinterface

// File: rtl/instr_field_decode.sv
// Purely combinational split of a 20-bit instruction word into its fields
// plus the register-usage and control-class flags used for hazard detection.
module instr_field_decode
  import instr_decode_ctrl_pkg::*;
(
  input  logic [INS_W-1:0] word,
  output logic [OPC_W-1:0] opcode,
  output logic [REG_W-1:0] rd,
  output logic [REG_W-1:0] rs,
  output logic [REG_W-1:0] rt,
  output logic [IMM_W-1:0] imm,
  output logic             reads_rs,
  output logic             reads_rt,
  output logic             is_ld,
  output logic             is_jmp,
  output logic             is_hlt
);

  assign opcode = word[OPC_LSB +: OPC_W];
  assign rd     = word[RD_LSB  +: REG_W];
  assign rs     = word[RS_LSB  +: REG_W];
  assign rt     = word[RT_LSB  +: REG_W];
  assign imm    = word[IMM_LSB +: IMM_W];

  assign is_ld  = (opcode == OP_LD);
  assign is_jmp = (opcode == OP_JMP);
  assign is_hlt = (opcode == OP_HLT);

  assign reads_rs = (opcode != OP_NOP) && !is_jmp && !is_hlt;
  // R-type class is the opcode[4:3]==00 group; stores also read rt as data.
  assign reads_rt = (opcode[OPC_W-1 -: 2] == 2'b00) || (opcode == OP_ST);

endmodule

// File: rtl/instr_decode_ctrl.sv
// Decode-stage controller: IF/ID and ID/EX registers, RUN/HALT FSM,
// unconditional-jump redirect and load-use stall generation.
module instr_decode_ctrl
  import instr_decode_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  instr_decode_ctrl_if.slave  bus
);

  logic [INS_W-1:0]  ifid_ins_q, ifid_ins_d;
  logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
  logic              ifid_valid_q, ifid_valid_d;
  idex_t             idex_q, idex_d;
  logic              idex_is_ld_q, idex_is_ld_d;
  state_e            state_q, state_d;

  logic [OPC_W-1:0]  dec_opcode;
  logic [REG_W-1:0]  dec_rd, dec_rs, dec_rt;
  logic [IMM_W-1:0]  dec_imm;
  logic              dec_reads_rs, dec_reads_rt;
  logic              dec_is_ld, dec_is_jmp, dec_is_hlt;

  logic              halt_active;
  logic              load_use;
  logic              take_jmp;

  instr_field_decode u_decode (
    .word     (ifid_ins_q),
    .opcode   (dec_opcode),
    .rd       (dec_rd),
    .rs       (dec_rs),
    .rt       (dec_rt),
    .imm      (dec_imm),
    .reads_rs (dec_reads_rs),
    .reads_rt (dec_reads_rt),
    .is_ld    (dec_is_ld),
    .is_jmp   (dec_is_jmp),
    .is_hlt   (dec_is_hlt)
  );

  // All control decisions depend only on registered state, never on ins.
  assign halt_active = (state_q == S_HALT);
  assign load_use    = idex_q.valid && idex_is_ld_q && ifid_valid_q &&
                       ((dec_reads_rs && (dec_rs == idex_q.rd)) ||
                        (dec_reads_rt && (dec_rt == idex_q.rd)));
  assign take_jmp    = ifid_valid_q && dec_is_jmp && !halt_active && !load_use;

  always_comb begin
    state_d      = state_q;
    ifid_ins_d   = ifid_ins_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    idex_d       = '0;
    idex_is_ld_d = 1'b0;

    if (!halt_active && !load_use) begin
      // The sequential fetch behind a taken jump is squashed into a bubble.
      if (take_jmp) begin
        ifid_ins_d   = NOP_WORD;
        ifid_pc_d    = '0;
        ifid_valid_d = 1'b0;
      end else begin
        ifid_ins_d   = bus.ins;
        ifid_pc_d    = bus.current_address;
        ifid_valid_d = 1'b1;
      end

      if (ifid_valid_q) begin
        idex_d.valid  = 1'b1;
        idex_d.opcode = dec_opcode;
        idex_d.rd     = dec_rd;
        idex_d.rs     = dec_rs;
        idex_d.rt     = dec_rt;
        idex_d.imm    = dec_imm;
        idex_d.pc     = ifid_pc_q;
        idex_is_ld_d  = dec_is_ld;
      end
    end

    if (!halt_active && ifid_valid_q && dec_is_hlt) begin
      state_d = S_HALT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_ins_q   <= NOP_WORD;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      idex_q       <= '0;
      idex_is_ld_q <= 1'b0;
      state_q      <= S_RUN;
    end else begin
      ifid_ins_q   <= ifid_ins_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      idex_q       <= idex_d;
      idex_is_ld_q <= idex_is_ld_d;
      state_q      <= state_d;
    end
  end

  assign bus.stall      = halt_active || load_use;
  assign bus.stall_pm   = halt_active || load_use;
  assign bus.pc_mux_sel = !take_jmp;
  assign bus.jmp_loc    = take_jmp ? dec_imm : '0;
  assign bus.halted     = halt_active;

  assign bus.id_valid   = idex_q.valid;
  assign bus.id_opcode  = idex_q.opcode;
  assign bus.id_rd      = idex_q.rd;
  assign bus.id_rs      = idex_q.rs;
  assign bus.id_rt      = idex_q.rt;
  assign bus.id_imm     = idex_q.imm;
  assign bus.id_pc      = idex_q.pc;

endmodule
